// File: rtl/qam_pkg.sv
// Shared QAM-chain constants: the 28-bit test pattern (MSB sent first) and rx state encoding.
package qam_pkg;

  localparam int PAT_LEN = 28;
  localparam logic [PAT_LEN-1:0] PATTERN = 28'h6CC1555;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } rx_state_t;

endpackage

// File: rtl/adat_err_cnt.sv
// Saturating error counter; count updates 1 clock after inc, no backpressure.
module adat_err_cnt #(
  parameter int ERR_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [ERR_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {ERR_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adat_rx.sv
// Serial pattern receiver: frame alignment, sin/cos pairing and bit-error counting.
// All outputs are registered, 1 clock after the data_change cycle; no backpressure.
module adat_rx
  import qam_pkg::*;
#(
  parameter int LOSS_THR = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             adat_be,
  input  logic             data_change,
  output logic             sym_sin,
  output logic             sym_cos,
  output logic             sym_valid,
  output logic             frame_start,
  output logic             locked,
  output logic [ERR_W-1:0] bit_err_cnt,
  output logic             err_pulse
);

  localparam int IDX_W  = $clog2(PAT_LEN);
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam int MISS_W = $clog2(LOSS_THR + 1);

  rx_state_t          state;
  // Only the 27 history bits are stored; the live bit completes the 28-bit window.
  logic [PAT_LEN-2:0] rx_shift;
  logic [PAT_LEN-1:0] window;
  logic [FILL_W-1:0]  fill;
  logic [IDX_W-1:0]   idx;
  logic [MISS_W-1:0]  miss;
  logic               pend_sin;
  logic               exp_bit;
  logic               mismatch;
  logic               drop;
  logic               last_idx;

  always_comb begin
    window   = {rx_shift, adat_be};
    exp_bit  = PATTERN[IDX_W'(PAT_LEN - 1) - idx];
    mismatch = (state == LOCKED) && data_change && (adat_be != exp_bit);
    drop     = mismatch && (miss == MISS_W'(LOSS_THR - 1));
    last_idx = (idx == IDX_W'(PAT_LEN - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SEARCH;
      rx_shift    <= '0;
      fill        <= '0;
      idx         <= '0;
      miss        <= '0;
      pend_sin    <= 1'b0;
      sym_sin     <= 1'b0;
      sym_cos     <= 1'b0;
      sym_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      sym_valid   <= 1'b0;
      frame_start <= 1'b0;
      err_pulse   <= 1'b0;
      if (data_change) begin
        rx_shift <= window[PAT_LEN-2:0];
        case (state)
          SEARCH: begin
            // The current bit is the 28th (or later) since the window was cleared.
            if ((fill >= FILL_W'(PAT_LEN - 1)) && (window == PATTERN)) begin
              state  <= LOCKED;
              locked <= 1'b1;
              idx    <= '0;
              miss   <= '0;
              fill   <= FILL_W'(PAT_LEN);
            end else if (fill != FILL_W'(PAT_LEN)) begin
              fill <= fill + 1'b1;
            end
          end
          LOCKED: begin
            err_pulse <= mismatch;
            if (drop) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              fill     <= '0;
              miss     <= '0;
              idx      <= '0;
              pend_sin <= 1'b0;
            end else begin
              miss        <= mismatch ? miss + 1'b1 : '0;
              idx         <= last_idx ? '0 : idx + 1'b1;
              frame_start <= last_idx;
              if (!idx[0]) begin
                pend_sin <= adat_be;
              end else begin
                sym_valid <= 1'b1;
                sym_sin   <= pend_sin;
                sym_cos   <= adat_be;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  adat_err_cnt #(
    .ERR_W(ERR_W)
  ) u_err_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (mismatch),
    .clr  (1'b0),
    .count(bit_err_cnt)
  );

endmodule

// File: tb/tb_adat_rx.sv
// Scoreboard bench for adat_rx: directed pattern streams, a wide and a 4-bit-counter instance.
module tb_adat_rx;
  import qam_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        adat_be = 1'b0;
  logic        data_change = 1'b0;
  logic        sym_sin, sym_cos, sym_valid, frame_start, locked, err_pulse;
  logic [15:0] bit_err_cnt;
  logic        s_sin, s_cos, s_valid, s_frame, s_locked, s_err;
  logic [3:0]  s_cnt;

  always #5 clock = ~clock;

  adat_rx #(.LOSS_THR(4), .ERR_W(16)) dut (
    .clock(clock), .reset(reset), .adat_be(adat_be), .data_change(data_change),
    .sym_sin(sym_sin), .sym_cos(sym_cos), .sym_valid(sym_valid),
    .frame_start(frame_start), .locked(locked), .bit_err_cnt(bit_err_cnt),
    .err_pulse(err_pulse)
  );

  adat_rx #(.LOSS_THR(4), .ERR_W(4)) u_sat (
    .clock(clock), .reset(reset), .adat_be(adat_be), .data_change(data_change),
    .sym_sin(s_sin), .sym_cos(s_cos), .sym_valid(s_valid),
    .frame_start(s_frame), .locked(s_locked), .bit_err_cnt(s_cnt),
    .err_pulse(s_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model of the receiver; it predicts output events into the queues.
  typedef struct {
    bit sin;
    bit cos;
  } sym_t;

  sym_t        sym_q[$];
  int          err_q[$];
  int          frame_q[$];
  logic [27:0] pat = PATTERN;
  logic [27:0] m_win = '0;
  bit          m_locked = 0;
  bit          m_pend = 0;
  int          m_fill = 0, m_idx = 0, m_miss = 0, m_cnt = 0, m_cnt4 = 0;
  int          sym_seen = 0, frame_seen = 0;

  task automatic model_reset();
    m_win = '0; m_locked = 0; m_pend = 0;
    m_fill = 0; m_idx = 0; m_miss = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic model_bit(input bit b);
    bit e;
    m_win = {m_win[26:0], b};
    if (!m_locked) begin
      if (m_fill < 28) m_fill++;
      if (m_fill == 28 && m_win == pat) begin
        m_locked = 1; m_idx = 0; m_miss = 0;
      end
    end else begin
      e = pat[27 - m_idx];
      if (b != e) begin
        m_miss++;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
        err_q.push_back(m_cnt);
      end else begin
        m_miss = 0;
      end
      if (m_miss == 4) begin
        m_locked = 0; m_fill = 0; m_miss = 0; m_idx = 0;
      end else begin
        if (m_idx % 2 == 0) m_pend = b;
        else sym_q.push_back('{m_pend, b});
        if (m_idx == 27) begin
          frame_q.push_back(m_cnt);
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic send(input bit b, input int gap);
    @(negedge clock);
    adat_be = b;
    data_change = 1'b1;
    model_bit(b);
    repeat (gap) begin
      @(negedge clock);
      data_change = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      data_change = 1'b0;
    end
  endtask

  task automatic send_pat(input int from, input int to, input int flo, input int fhi, input int gap);
    bit b;
    for (int i = from; i <= to; i++) begin
      b = pat[27 - i];
      if (i >= flo && i <= fhi) b = ~b;
      send(b, gap);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (sym_valid) begin
        if (sym_q.size() == 0) check("sym_unexpected", 1, 0);
        else begin
          sym_t s;
          s = sym_q.pop_front();
          check("sym_sin", {31'b0, sym_sin}, {31'b0, s.sin});
          check("sym_cos", {31'b0, sym_cos}, {31'b0, s.cos});
          sym_seen++;
        end
      end
      if (err_pulse) begin
        if (err_q.size() == 0) check("err_unexpected", 1, 0);
        else check("err_cnt", {16'b0, bit_err_cnt}, err_q.pop_front());
      end
      if (frame_start) begin
        if (frame_q.size() == 0) check("frame_unexpected", 1, 0);
        else begin
          check("frame_cnt", {16'b0, bit_err_cnt}, frame_q.pop_front());
          frame_seen++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_locked", {31'b0, locked}, 0);
    check("rst_sym_valid", {31'b0, sym_valid}, 0);
    check("rst_err_pulse", {31'b0, err_pulse}, 0);
    check("rst_frame", {31'b0, frame_start}, 0);
    check("rst_cnt", {16'b0, bit_err_cnt}, 0);
    reset = 1'b0;

    // Acquisition from phase 0: 27 bits are not enough, the 28th locks.
    send_pat(0, 26, 99, 99, 2);
    idle(1);
    check("lock_after_27", {31'b0, locked}, 0);
    send_pat(27, 27, 99, 99, 0);
    idle(1);
    check("lock_after_28", {31'b0, locked}, 1);

    // First pair is pattern bits 0/1 = 0,1.
    send_pat(0, 1, 99, 99, 1);
    check("first_pair_vld", {31'b0, sym_valid}, 1);
    check("first_pair_sin", {31'b0, sym_sin}, 0);
    check("first_pair_cos", {31'b0, sym_cos}, 1);
    send_pat(2, 27, 99, 99, 1);
    send_pat(0, 27, 99, 99, 1);
    idle(1);
    check("sym_per_2_periods", sym_seen, 28);
    check("frames_2_periods", frame_seen, 2);
    check("clean_cnt", {16'b0, bit_err_cnt}, 0);

    // Single flipped bit: counted, lock kept.
    send_pat(0, 27, 10, 10, 1);
    idle(1);
    check("one_err_cnt", {16'b0, bit_err_cnt}, 1);
    check("one_err_locked", {31'b0, locked}, 1);

    // Four consecutive flips drop lock; count held through relock.
    send_pat(0, 6, 3, 6, 1);
    idle(1);
    check("loss_locked", {31'b0, locked}, 0);
    check("loss_cnt", {16'b0, bit_err_cnt}, 5);
    send_pat(7, 27, 99, 99, 1);
    send_pat(0, 27, 99, 99, 1);
    idle(1);
    check("relock_locked", {31'b0, locked}, 1);
    check("relock_cnt", {16'b0, bit_err_cnt}, 5);

    // Reset mid-frame, coincident with a strobe.
    send_pat(0, 12, 99, 99, 1);
    idle(1);
    check("pre_rst_sym_q", sym_q.size(), 0);
    @(negedge clock);
    reset = 1'b1;
    adat_be = 1'b1;
    data_change = 1'b1;
    @(negedge clock);
    check("mid_rst_locked", {31'b0, locked}, 0);
    check("mid_rst_sym", {29'b0, sym_valid, sym_sin, sym_cos}, 0);
    check("mid_rst_pulses", {30'b0, err_pulse, frame_start}, 0);
    check("mid_rst_cnt", {16'b0, bit_err_cnt}, 0);
    reset = 1'b0;
    data_change = 1'b0;
    model_reset();

    // Phase-5 start with data_change held high: lock only after 23+28 bits.
    send_pat(5, 27, 99, 99, 0);
    send_pat(0, 26, 99, 99, 0);
    idle(1);
    check("ph5_lock_50", {31'b0, locked}, 0);
    send_pat(27, 27, 99, 99, 0);
    idle(1);
    check("ph5_lock_51", {31'b0, locked}, 1);
    send_pat(0, 1, 99, 99, 1);
    check("ph5_pair_sin", {31'b0, sym_sin}, 0);
    check("ph5_pair_cos", {31'b0, sym_cos}, 1);
    send_pat(2, 27, 99, 99, 1);

    // Repeated lock loss: 4 errors per round, 5 rounds.
    for (int r = 0; r < 5; r++) begin
      send_pat(0, 27, 0, 3, 1);
      send_pat(0, 27, 99, 99, 1);
    end
    idle(1);
    check("sat_cnt4", {28'b0, s_cnt}, 15);
    check("sat_cnt4_model", {28'b0, s_cnt}, m_cnt4);
    check("sat_cnt16", {16'b0, bit_err_cnt}, 20);
    check("sat_locked", {31'b0, locked}, 1);

    idle(2);
    check("sym_q_empty", sym_q.size(), 0);
    check("err_q_empty", err_q.size(), 0);
    check("frame_q_empty", frame_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
